// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control path: state and direction
// encodings, counter width and small key-decoding helpers.
package snake_pkg;

    // Width of every timing counter; wide enough for the 50 MHz one-second divider.
    localparam int CNT_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_OVER   = 2'b10,
        ST_PAUSED = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // Opposite pairs differ only in the LSB (up/down, left/right).
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    // keys = {RIGHT, LEFT, DOWN, UP}; true when exactly one key is pressed.
    function automatic logic one_key(input logic [3:0] keys);
        case (keys)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Direction of a single pressed key (only meaningful when one_key is true).
    function automatic dir_t key_to_dir(input logic [3:0] keys);
        case (keys)
            4'b0010: return DIR_DOWN;
            4'b0100: return DIR_LEFT;
            4'b1000: return DIR_RIGHT;
            default: return DIR_UP;
        endcase
    endfunction

endpackage

// File: rtl/tick_div.sv
// Programmable divider: counts enabled cycles and emits a registered one-cycle
// tick every (div_m1 + 1) enabled cycles. clr and RST zero the count.
module tick_div #(
    parameter int CNT_W = 26
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div_m1,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;

    // Count while enabled; hold the count (pause) when not enabled.
    always_ff @(posedge SYS_CLK) begin
        if (RST || clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (en) begin
            if (cnt_reg >= div_m1) begin
                cnt_reg  <= '0;
                tick_reg <= 1'b1;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
                tick_reg <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/game_sequencer.sv
// Snake game sequencer: game state machine, step/second/scan strobes, BCD
// play timer, direction filtering and item beep.
// Optional build macro SNAKE_SPEEDUP_EN: each item shortens the step period
// by STEP_DIV/8 down to STEP_DIV/4; otherwise the step period is fixed.
module game_sequencer
    import snake_pkg::*;
#(
    parameter int STEP_DIV = 4500000,
    parameter int SEC_DIV  = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int BEEP_CYC = 5000000
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       PAUSE,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       item_hit,
    input  logic       collide,
    output logic       step_en,
    output logic       scan_en,
    output logic       sec_en,
    output logic [1:0] move_dir,
    output logic [1:0] state,
    output logic [3:0] time_num10,
    output logic [3:0] time_num01,
    output logic       beep
);

    localparam int TK_STEP = 0;
    localparam int TK_SEC  = 1;
    localparam int TK_SCAN = 2;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SEC_M1    = CNT_W'(SEC_DIV - 1);
    localparam logic [CNT_W-1:0] SCAN_M1   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_CYC - 1);

    game_state_t      state_reg;
    dir_t             move_dir_reg;
    dir_t             pending_dir_reg;
    logic [3:0]       t10_reg;
    logic [3:0]       t01_reg;
    logic             beep_reg;
    logic [CNT_W-1:0] beep_cnt_reg;

    logic [3:0]       keys;
    logic             key_valid;
    dir_t             key_dir;
    logic             in_play;
    logic             run_timer;
    logic             timer_roll;
    logic             go_over;
    logic [CNT_W-1:0] step_div_m1;

    logic [2:0]       tick_en;
    logic [2:0]       tick_clr;
    logic [2:0]       tick_out;
    logic [CNT_W-1:0] tick_div_m1 [3];

    assign keys       = {RIGHT, LEFT, DOWN, UP};
    assign key_valid  = one_key(keys);
    assign key_dir    = key_to_dir(keys);
    assign in_play    = (state_reg == ST_PLAY);
    assign run_timer  = in_play || (state_reg == ST_PAUSED);
    // 59 -> 60 rollover ends the game whether playing or paused.
    assign timer_roll = sec_en && run_timer && (t10_reg == 4'd5) && (t01_reg == 4'd9);
    assign go_over    = timer_roll || (in_play && collide);

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] STEP_FULL  = CNT_W'(STEP_DIV);
    localparam logic [CNT_W-1:0] STEP_DEC   = CNT_W'(STEP_DIV / 8);
    localparam logic [CNT_W-1:0] STEP_FLOOR = CNT_W'(STEP_DIV / 4);

    logic [CNT_W-1:0] step_period_reg;

    // Shorten the step period on every item eaten, saturating at the floor.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            step_period_reg <= STEP_FULL;
        end else if (in_play && item_hit) begin
            if (step_period_reg >= STEP_FLOOR + STEP_DEC)
                step_period_reg <= step_period_reg - STEP_DEC;
            else
                step_period_reg <= STEP_FLOOR;
        end
    end

    assign step_div_m1 = step_period_reg - ONE;
`else
    assign step_div_m1 = CNT_W'(STEP_DIV) - ONE;
`endif

    // Step and second dividers run only in PLAY and restart from zero on each
    // new game; the scan divider never stops.
    assign tick_en[TK_STEP]      = in_play;
    assign tick_en[TK_SEC]       = in_play;
    assign tick_en[TK_SCAN]      = 1'b1;
    assign tick_clr[TK_STEP]     = (state_reg == ST_IDLE);
    assign tick_clr[TK_SEC]      = (state_reg == ST_IDLE);
    assign tick_clr[TK_SCAN]     = 1'b0;
    assign tick_div_m1[TK_STEP]  = step_div_m1;
    assign tick_div_m1[TK_SEC]   = SEC_M1;
    assign tick_div_m1[TK_SCAN]  = SCAN_M1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_div
            tick_div #(
                .CNT_W (CNT_W)
            ) u_tick_div (
                .SYS_CLK (SYS_CLK),
                .RST     (RST),
                .en      (tick_en[gi]),
                .clr     (tick_clr[gi]),
                .div_m1  (tick_div_m1[gi]),
                .tick    (tick_out[gi])
            );
        end
    endgenerate

    assign step_en = tick_out[TK_STEP];
    assign sec_en  = tick_out[TK_SEC];
    assign scan_en = tick_out[TK_SCAN];

    // Game state machine; game over wins over a simultaneous pause request.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (key_valid)
                        state_reg <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (go_over)
                        state_reg <= ST_OVER;
                    else if (PAUSE)
                        state_reg <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (go_over)
                        state_reg <= ST_OVER;
                    else if (!PAUSE)
                        state_reg <= ST_PLAY;
                end
                ST_OVER: begin
                    state_reg <= ST_OVER;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // BCD elapsed-seconds timer; saturates at 60.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            t10_reg <= 4'd0;
            t01_reg <= 4'd0;
        end else if (sec_en && run_timer && (t10_reg != 4'd6)) begin
            if (t01_reg == 4'd9) begin
                t01_reg <= 4'd0;
                t10_reg <= t10_reg + 4'd1;
            end else begin
                t01_reg <= t01_reg + 4'd1;
            end
        end
    end

    // Latch a legal turn request; apply it only on a step so a quick
    // two-key reversal inside one step cannot fold the snake onto itself.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            move_dir_reg    <= DIR_UP;
            pending_dir_reg <= DIR_UP;
        end else begin
            if ((state_reg == ST_IDLE || in_play) && key_valid &&
                (key_dir != reverse_dir(move_dir_reg)))
                pending_dir_reg <= key_dir;
            if (step_en)
                move_dir_reg <= pending_dir_reg;
        end
    end

    // Retriggerable beep of BEEP_CYC cycles after an item; silent once over.
    always_ff @(posedge SYS_CLK) begin
        if (RST || go_over || (state_reg == ST_OVER)) begin
            beep_cnt_reg <= '0;
            beep_reg     <= 1'b0;
        end else if (in_play && item_hit) begin
            beep_cnt_reg <= BEEP_LOAD;
            beep_reg     <= 1'b1;
        end else if (beep_cnt_reg != '0) begin
            beep_cnt_reg <= beep_cnt_reg - ONE;
        end else begin
            beep_reg <= 1'b0;
        end
    end

    assign state      = state_reg;
    assign move_dir   = move_dir_reg;
    assign time_num10 = t10_reg;
    assign time_num01 = t01_reg;
    assign beep       = beep_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with small dividers
// (STEP 4, SEC 10, SCAN 3, BEEP 8). Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_game_sequencer;

    logic       SYS_CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PAUSE = 1'b0;
    logic       UP = 1'b0;
    logic       DOWN = 1'b0;
    logic       LEFT = 1'b0;
    logic       RIGHT = 1'b0;
    logic       item_hit = 1'b0;
    logic       collide = 1'b0;
    logic       step_en;
    logic       scan_en;
    logic       sec_en;
    logic [1:0] move_dir;
    logic [1:0] state;
    logic [3:0] time_num10;
    logic [3:0] time_num01;
    logic       beep;

    int n_tests = 0;
    int n_fail  = 0;

    game_sequencer #(
        .STEP_DIV (4),
        .SEC_DIV  (10),
        .SCAN_DIV (3),
        .BEEP_CYC (8)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .PAUSE      (PAUSE),
        .UP         (UP),
        .DOWN       (DOWN),
        .LEFT       (LEFT),
        .RIGHT      (RIGHT),
        .item_hit   (item_hit),
        .collide    (collide),
        .step_en    (step_en),
        .scan_en    (scan_en),
        .sec_en     (sec_en),
        .move_dir   (move_dir),
        .state      (state),
        .time_num10 (time_num10),
        .time_num01 (time_num01),
        .beep       (beep)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        {PAUSE, UP, DOWN, LEFT, RIGHT, item_hit, collide} = '0;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int n_step;
        int n_sec;
        int n_scan;

        // ---- IDLE start ----
        do_reset();
        check_eq("rst_state", state, 2'b00);
        check_eq("rst_dir", move_dir, 2'b00);
        check_eq("rst_time", {time_num10, time_num01}, 8'h00);
        check_eq("rst_beep", beep, 1'b0);
        check_eq("rst_strobes", {step_en, sec_en, scan_en}, 3'b000);
        UP = 1'b1; RIGHT = 1'b1;
        tick();
        check_eq("two_keys_idle", state, 2'b00);
        UP = 1'b0;
        tick();
        RIGHT = 1'b0;
        check_eq("start_play", state, 2'b01);
        n_step = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_step += int'(step_en);
        end
        check_eq("no_early_step", n_step, 0);
        tick();
        check_eq("first_step", step_en, 1'b1);
        check_eq("dir_before_step", move_dir, 2'b00);
        tick();
        check_eq("dir_after_step", move_dir, 2'b11);
        check_eq("step_one_cycle", step_en, 1'b0);

        // ---- reversal rejection ----
        do_reset();
        UP = 1'b1;
        tick();
        UP = 1'b0; DOWN = 1'b1;
        repeat (8) tick();
        check_eq("reverse_held", move_dir, 2'b00);
        check_eq("rev_step_e8", step_en, 1'b1);
        DOWN = 1'b0; LEFT = 1'b1;
        tick();
        LEFT = 1'b0; DOWN = 1'b1;
        tick();
        DOWN = 1'b0;
        tick();
        tick();
        check_eq("rev_step_e12", step_en, 1'b1);
        check_eq("rev_dir_pre", move_dir, 2'b00);
        tick();
        check_eq("left_only", move_dir, 2'b10);

        // ---- pause ----
        do_reset();
        RIGHT = 1'b1;
        tick();
        RIGHT = 1'b0;
        tick();
        tick();
        PAUSE = 1'b1;
        tick();
        check_eq("paused", state, 2'b11);
        n_step = 0; n_sec = 0; n_scan = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_step += int'(step_en);
            n_sec  += int'(sec_en);
            n_scan += int'(scan_en);
        end
        check_eq("pause_no_step", n_step, 0);
        check_eq("pause_no_sec", n_sec, 0);
        check_eq("pause_scan", n_scan, 7);
        check_eq("pause_time", {time_num10, time_num01}, 8'h00);
        PAUSE = 1'b0;
        tick();
        check_eq("resume_play", state, 2'b01);
        check_eq("resume_no_step", step_en, 1'b0);
        tick();
        check_eq("resume_step", step_en, 1'b1);
        repeat (6) tick();
        check_eq("resume_sec", sec_en, 1'b1);
        tick();
        check_eq("resume_time", {time_num10, time_num01}, 8'h01);

        // ---- beep ----
        do_reset();
        RIGHT = 1'b1;
        tick();
        RIGHT = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            check_eq($sformatf("beep_t%0d", k), beep, (k >= 1 && k <= 13) ? 1'b1 : 1'b0);
            item_hit = (k == 0 || k == 5) ? 1'b1 : 1'b0;
            tick();
        end
        item_hit = 1'b0;

        // ---- collide + pause, reset out of OVER ----
        do_reset();
        collide = 1'b1;
        tick();
        collide = 1'b0;
        check_eq("idle_ignores_collide", state, 2'b00);
        RIGHT = 1'b1;
        tick();
        RIGHT = 1'b0;
        repeat (25) tick();
        check_eq("pre_over_time", {time_num10, time_num01}, 8'h02);
        check_eq("pre_over_dir", move_dir, 2'b11);
        collide = 1'b1; PAUSE = 1'b1;
        tick();
        collide = 1'b0;
        check_eq("over_beats_pause", state, 2'b10);
        repeat (3) tick();
        RIGHT = 1'b1;
        tick();
        check_eq("over_held", state, 2'b10);
        RIGHT = 1'b0; PAUSE = 1'b0;
        item_hit = 1'b1;
        tick();
        item_hit = 1'b0;
        check_eq("over_no_beep", beep, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("rst_over_state", state, 2'b00);
        check_eq("rst_over_time", {time_num10, time_num01}, 8'h00);
        check_eq("rst_over_dir", move_dir, 2'b00);

        // ---- timeout ----
        do_reset();
        RIGHT = 1'b1;
        tick();
        RIGHT = 1'b0;
        repeat (591) tick();
        check_eq("time_59", {time_num10, time_num01}, 8'h59);
        check_eq("still_play", state, 2'b01);
        repeat (9) tick();
        check_eq("sec_60th", sec_en, 1'b1);
        check_eq("play_before_roll", state, 2'b01);
        tick();
        check_eq("timeout_state", state, 2'b10);
        check_eq("timeout_time", {time_num10, time_num01}, 8'h60);
        n_step = 0; n_sec = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_step += int'(step_en);
            n_sec  += int'(sec_en);
        end
        check_eq("over_no_step", n_step, 0);
        check_eq("over_no_sec", n_sec, 0);
        check_eq("time_holds_60", {time_num10, time_num01}, 8'h60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4500000, meaning SYS_CLK cycles per snake step.
REQ-002 SHALL have parameter SEC_DIV, default 50000000, meaning SYS_CLK cycles per game second.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, meaning SYS_CLK cycles per LED row-scan advance.
REQ-004 SHALL have parameter BEEP_CYC, default 5000000, meaning beep length in SYS_CLK cycles.
REQ-005 SHALL have port SYS_CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have ports PAUSE, UP, DOWN, LEFT, RIGHT, each input, 1 bit: level-sensitive, already synchronized.
REQ-008 SHALL have ports item_hit and collide, each input, 1 bit: one-cycle pulses from the game-body datapath.
REQ-009 SHALL have ports step_en, scan_en and sec_en, each output, 1 bit: one-cycle strobes.
REQ-010 SHALL have port move_dir, output, 2 bits: 00 up, 01 down, 10 left, 11 right.
REQ-011 SHALL have port state, output, 2 bits: 00 IDLE, 01 PLAY, 10 OVER, 11 PAUSED.
REQ-012 SHALL have ports time_num10 and time_num01, each output, 4 bits: BCD elapsed seconds.
REQ-013 SHALL have port beep, output, 1 bit: active-high buzzer enable.

Function
REQ-014 SHALL implement state transitions: IDLE->PLAY when exactly one direction key is high; PLAY->PAUSED when PAUSE=1; PAUSED->PLAY when PAUSE=0; PLAY or PAUSED->OVER on its cause; OVER is held until RST.
REQ-015 SHALL enter OVER from PLAY on collide=1 or on a timer rollover 59->60; OVER has priority over PAUSED when both occur in the same cycle.
REQ-016 SHALL pulse step_en for one cycle every STEP_DIV cycles, only in PLAY; the counter is frozen in PAUSED and cleared on the IDLE->PLAY transition.
REQ-017 SHALL pulse sec_en every SEC_DIV cycles under the same gating as step_en, using an independent counter.
REQ-018 SHALL pulse scan_en every SCAN_DIV cycles in all states, free-running.
REQ-019 SHALL increment the BCD timer on sec_en (01 wraps 9->0 with carry into 10); on reaching 60 it holds 6/0 and forces OVER.
REQ-020 SHALL latch a key into pending_dir only when exactly one key is high and that key is not the reverse of the current move_dir.
REQ-021 SHALL copy pending_dir to move_dir only in the cycle step_en=1, so there is at most one turn per step and a two-key reversal within one step is rejected.
REQ-022 SHALL hold beep high for BEEP_CYC cycles after item_hit in PLAY; a new item_hit restarts the count; beep is forced low in OVER.
REQ-023 SHALL ignore item_hit and collide outside PLAY.
REQ-024 SHALL keep all counters at least 26 bits wide and compare them with >= DIV-1 so the pulse period is exactly DIV.

Reset
REQ-025 SHALL, on RST=1 at a clock edge, set state=IDLE, move_dir=00, pending_dir=00, timer=00, beep=0, all strobes 0 and all counters 0.
REQ-026 SHALL let RST override every other input in any state, including mid-beep and during OVER.

Configuration
REQ-027 SHALL, with SNAKE_SPEEDUP_EN defined, reduce the step period by STEP_DIV/8 on each item_hit, down to a floor of STEP_DIV/4, and restore it to STEP_DIV on reset.
REQ-028 SHALL, with SNAKE_SPEEDUP_EN undefined, keep the step period constant at STEP_DIV and omit the period register.

Structure
REQ-029 SHALL take the state encodings, direction encodings and a reverse-direction function from shared package snake_pkg.
REQ-030 SHALL instantiate sub-module tick_div (parameterized counter with enable, clear and one-cycle pulse) three times: step, sec and scan.

Verification
REQ-031 SHALL cover IDLE start: with STEP_DIV=4, reset then RIGHT=1 -> state=01 next cycle, first step_en 4 cycles later, move_dir=11 on that step.
REQ-032 SHALL cover reversal: move_dir=00, press DOWN -> move_dir stays 00; press LEFT then DOWN within one step -> move_dir=10 only.
REQ-033 SHALL cover pause: PAUSE=1 for 20 cycles in PLAY -> no step_en or sec_en, timer frozen, scan_en continues; release -> step_en resumes at the remaining count.
REQ-034 SHALL cover timeout: SEC_DIV=10, run 600 cycles -> timer reads 6/0, state=10, step_en stops.
REQ-035 SHALL cover simultaneous events: collide=1 and PAUSE=1 in the same cycle -> state=10; RST during OVER -> state=00, timer=00.
REQ-036 SHALL cover beep: BEEP_CYC=8, item_hit at t and t+5 -> beep high from t+1 through t+13.
